pixel_word_packer: RTL

Serial-to-parallel packer that sits directly upstream of the per-row image registers in the digit-recognition datapath. It accepts one binary pixel per handshake from the drawing/input front end, packs each row of pixels into a `WordBits`-wide word, and writes that word to the row-register bank. The write strobe plays the role of that bank's `ClockEnable`, and the address selects the bank's chip select. It shares the global `Clock`, `Reset` and `Tick` with the bank, so a word is captured on exactly the Tick on which the strobe is high.

---
 rtl/pixel_word_packer.sv | 95 +++++++++
 1 files changed

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs one binary pixel per handshake into WordBits-wide row words for the row-register bank.
// Define PIXEL_PACKER_OVERRUN_EN to build the sticky Overrun detector; otherwise Overrun is tied to 0.
module pixel_word_packer #(
  parameter int WordBits = 28,
  parameter int NrOfRows = 28,
  parameter int AddrBits = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                Start,
  input  logic                PixValid,
  input  logic                PixData,
  output logic                PixReady,
  output logic [WordBits-1:0] WordOut,
  output logic                WordWe,
  output logic [AddrBits-1:0] WordAddr,
  output logic                Busy,
  output logic                FrameDone,
  output logic                Overrun
);
  localparam int ColBits = $clog2(WordBits + 1);
  localparam logic [ColBits-1:0] LastCol = ColBits'(WordBits - 1);
  localparam logic [AddrBits-1:0] LastRow = AddrBits'(NrOfRows - 1);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state, state_nxt;
  logic [WordBits-1:0] sr, sr_nxt, word, word_nxt;
  logic [ColBits-1:0] col, col_nxt;
  logic [AddrBits-1:0] row, row_nxt;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      sr    <= '0;
      word  <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      word  <= word_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end
  // Every update is gated by Tick so the block freezes completely between Ticks.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    word_nxt  = word;
    col_nxt   = col;
    row_nxt   = row;
    if (Tick) begin
      case (state)
        IDLE: if (Start) begin
          state_nxt = FILL;
          sr_nxt    = '0;
          col_nxt   = '0;
          row_nxt   = '0;
        end
        FILL: if (PixValid) begin
          sr_nxt  = {sr[WordBits-2:0], PixData};
          col_nxt = col + 1'b1;
          if (col == LastCol) begin
            state_nxt = WRITE;
            word_nxt  = {sr[WordBits-2:0], PixData};
          end
        end
        WRITE: if (row == LastRow) state_nxt = DONE;
        else begin
          state_nxt = FILL;
          row_nxt   = row + 1'b1;
          col_nxt   = '0;
        end
        DONE: state_nxt = IDLE;
      endcase
    end
  end
  assign PixReady  = state == FILL;
  assign WordWe    = state == WRITE;
  assign FrameDone = state == DONE;
  assign Busy      = state != IDLE;
  assign WordOut   = word;
  assign WordAddr  = row;
`ifdef PIXEL_PACKER_OVERRUN_EN
  logic overrun;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) overrun <= 1'b0;
    else if (Tick && state == IDLE && Start) overrun <= 1'b0;
    else if (Tick && PixValid && (state == WRITE || state == DONE)) overrun <= 1'b1;
  end
  assign Overrun = overrun;
`else
  assign Overrun = 1'b0;
`endif
endmodule
